// File: rtl/knight_pkg.sv
// Shared constants and the perceptual gamma table for the knight_trail afterglow stage.
// The table is only consulted when KNIGHT_TRAIL_GAMMA_EN is defined.
package knight_pkg;

    localparam int KT_W         = 8;
    localparam int KT_LW        = 4;
    localparam int KT_LMAX      = (1 << KT_LW) - 1;
    localparam int KT_DECAY_DIV = 16;

    // Maps a 4-bit linear brightness level to PWM on-cycles per frame.
    function automatic logic [3:0] gamma4(input logic [3:0] lvl);
        logic [3:0] g;
        case (lvl)
            4'd0:    g = 4'd0;
            4'd1:    g = 4'd0;
            4'd2:    g = 4'd1;
            4'd3:    g = 4'd1;
            4'd4:    g = 4'd1;
            4'd5:    g = 4'd2;
            4'd6:    g = 4'd2;
            4'd7:    g = 4'd3;
            4'd8:    g = 4'd4;
            4'd9:    g = 4'd5;
            4'd10:   g = 4'd6;
            4'd11:   g = 4'd7;
            4'd12:   g = 4'd9;
            4'd13:   g = 4'd11;
            4'd14:   g = 4'd13;
            default: g = 4'd15;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/trail_cell.sv
// One LED of the afterglow trail: brightness level register, load/decay and PWM compare.
// With KNIGHT_TRAIL_GAMMA_EN defined the compare uses the gamma-mapped level (LW=4 only).
module trail_cell
    import knight_pkg::*;
#(
    parameter int LW = KT_LW
) (
    input  logic          ck,
    input  logic          res,
    input  logic          in,
    input  logic          dt,
    input  logic [LW-1:0] pcnt,
    output logic          out
);

    localparam logic [LW-1:0] LMAX = {LW{1'b1}};

    logic [LW-1:0] level;
    logic [LW-1:0] eff;

`ifdef KNIGHT_TRAIL_GAMMA_EN
    assign eff = gamma4(level);
`else
    assign eff = level;
`endif

    // A live input bit beats a coincident decay tick; zero never wraps.
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            level <= '0;
        end else if (in) begin
            level <= LMAX;
        end else if (dt && (level != '0)) begin
            level <= level - 1'b1;
        end
    end

    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            out <= 1'b0;
        end else begin
            out <= (eff > pcnt);
        end
    end

endmodule

// File: rtl/knight_trail.sv
// knight_trail: turns the scanner's on/off pattern into a PWM-rendered fading trail.
// Optional gamma compare is enabled by defining KNIGHT_TRAIL_GAMMA_EN.
module knight_trail
    import knight_pkg::*;
#(
    parameter int W         = KT_W,
    parameter int LW        = KT_LW,
    parameter int DECAY_DIV = KT_DECAY_DIV
) (
    input  logic         ck,
    input  logic         res,
    input  logic [W-1:0] in,
    output logic [W-1:0] out,
    output logic         frame
);

    localparam int            DW    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
    localparam logic [LW-1:0] PLAST = LW'((1 << LW) - 2);
    localparam logic [DW-1:0] DLAST = DW'(DECAY_DIV - 1);

    logic [LW-1:0] pcnt;
    logic [DW-1:0] dcnt;
    logic          plast;
    logic          dt;

    assign plast = (pcnt == PLAST);
    assign dt    = plast && (dcnt == DLAST);

    // Frame is LMAX cycles long, so pcnt never reaches LMAX itself.
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            pcnt  <= '0;
            dcnt  <= '0;
            frame <= 1'b0;
        end else begin
            frame <= plast;
            if (plast) begin
                pcnt <= '0;
                dcnt <= (dcnt == DLAST) ? '0 : dcnt + 1'b1;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < W; i++) begin : g_cell
        trail_cell #(.LW(LW)) u_cell (
            .ck  (ck),
            .res (res),
            .in  (in[i]),
            .dt  (dt),
            .pcnt(pcnt),
            .out (out[i])
        );
    end

endmodule

// File: tb/tb_knight_trail.sv
// Self-checking bench for knight_trail against a closed-form brightness model.
module tb_knight_trail;

    localparam int W    = 8;
    localparam int LMAX = 15;
    localparam int PER  = 15 * 16;

    logic         ck = 1'b0;
    logic         res = 1'b0;
    logic [W-1:0] in = '0;
    logic [W-1:0] out;
    logic         frame;

    knight_trail dut (
        .ck   (ck),
        .res  (res),
        .in   (in),
        .out  (out),
        .frame(frame)
    );

    always #5 ck = ~ck;

    int total = 0;
    int bad   = 0;
    int n;
    int hit[W];
    int duty[W];

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (edge %0d)", tag, obs, exp, n);
        end
    endtask

    // Level after edge m: LMAX at the last hit, minus decay ticks strictly after it.
    function automatic int lvl(input int i, input int m);
        int d;
        if (hit[i] < 0 || m < 0 || hit[i] > m) return 0;
        d = (m + 1) / PER - (hit[i] + 1) / PER;
        return (d >= LMAX) ? 0 : LMAX - d;
    endfunction

    function automatic int eff(input int l);
`ifdef KNIGHT_TRAIL_GAMMA_EN
        int tbl[16] = '{0,0,1,1,1,2,2,3,4,5,6,7,9,11,13,15};
        return tbl[l];
`else
        return l;
`endif
    endfunction

    function automatic void model_reset();
        n = 0;
        for (int i = 0; i < W; i++) begin
            hit[i]  = -1;
            duty[i] = 0;
        end
    endfunction

    task automatic step(input logic [W-1:0] v);
        logic [W-1:0] exp_out;
        int fs;
        @(negedge ck);
        in = v;
        @(posedge ck);
        for (int i = 0; i < W; i++)
            exp_out[i] = (eff(lvl(i, n - 1)) > (n % LMAX));
        for (int i = 0; i < W; i++)
            if (v[i]) hit[i] = n;
        #1;
        chk("out", int'(out), int'(exp_out));
        chk("frame", int'(frame), int'(n % LMAX == LMAX - 1));
        if (n % LMAX == 0)
            for (int i = 0; i < W; i++) duty[i] = 0;
        for (int i = 0; i < W; i++) duty[i] += int'(out[i]);
        if (n % LMAX == LMAX - 1) begin
            fs = n - (LMAX - 1);
            for (int i = 0; i < W; i++)
                if (hit[i] < fs)
                    chk($sformatf("duty%0d", i), duty[i], eff(lvl(i, fs - 1)));
        end
        n++;
    endtask

    task automatic mid_reset();
        int first;
        #2 res = 1'b0;
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_frame", int'(frame), 0);
        in = '0;
        @(posedge ck);
        #2 res = 1'b1;
        model_reset();
        first = -1;
        for (int k = 1; k <= 40 && first < 0; k++) begin
            step('0);
            if (frame) first = k;
        end
        chk("first_frame", first, LMAX);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge ck);
        #1;
        chk("reset_out", int'(out), 0);
        chk("reset_frame", int'(frame), 0);
        #2 res = 1'b1;

        // held bit, then async reset partway through a frame
        for (int k = 0; k < 500; k++) step(8'h01);
        mid_reset();

        // single one-cycle hit, then the full fade
        step(8'h01);
        for (int k = 0; k < 3700; k++) step(8'h00);
        chk("fade_end", int'(out), 0);

        // hit coincident with a decay tick
        while (n % PER != PER - 1) step(8'h00);
        step(8'h80);
        for (int k = 0; k < 30; k++) step(8'h00);

        // scanner-like sweep
        for (int k = 0; k < PER; k++) step(8'h01);
        for (int k = 0; k < PER; k++) step(8'h02);
        for (int k = 0; k < PER; k++) step(8'h04);
        for (int k = 0; k < 60; k++) step(8'h00);

        // sparse random hits with one random reset
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 19) == 0) ? 8'($urandom) : 8'h00);
            if (k == 1700) mid_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
